// File: rtl/lz77_pkg.sv
// Shared types and defaults for the LZ77 decoder slice.
package lz77_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT,
        DONE
    } state_t;

    localparam logic [7:0] LZ77_END_CHAR     = 8'h24;
    localparam int         LZ77_SEARCH_DEPTH = 7;
    localparam int         LZ77_MAX_LEN      = 2;
    localparam int         LZ77_OFFSET_W     = 4;
    localparam int         LZ77_LEN_W        = 3;

endpackage

// File: rtl/lz77_search_buf.sv
// Sliding search buffer: newest character at entry 0, one combinational read port by offset.
module lz77_search_buf
    import lz77_pkg::*;
#(
    parameter int SEARCH_DEPTH = LZ77_SEARCH_DEPTH,
    parameter int OFFSET_W     = LZ77_OFFSET_W,
    parameter int FILL_W       = $clog2(SEARCH_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [7:0]          push_data,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic [7:0]          rd_data,
    output logic [FILL_W-1:0]   fill
);

    logic [7:0] sbuf [SEARCH_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                sbuf[i] <= 8'h00;
            end
            fill <= '0;
        end else if (push) begin
            sbuf[0] <= push_data;
            for (int i = 1; i < SEARCH_DEPTH; i++) begin
                sbuf[i] <= sbuf[i-1];
            end
            if (int'(fill) < SEARCH_DEPTH) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Offsets past the end of the buffer read as zero, same as never-written entries.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < SEARCH_DEPTH; i++) begin
            if (int'(rd_offset) == i) begin
                rd_data = sbuf[i];
            end
        end
    end

endmodule

// File: rtl/lz77_decoder.sv
// Streaming LZ77 token decoder, one output character per cycle.
// Define LZ77_DEC_CHECK_EN to build the sticky token-legality check driving err.
module lz77_decoder
    import lz77_pkg::*;
#(
    parameter int SEARCH_DEPTH = LZ77_SEARCH_DEPTH,
    parameter int MAX_LEN      = LZ77_MAX_LEN,
    parameter int OFFSET_W     = LZ77_OFFSET_W,
    parameter int LEN_W        = LZ77_LEN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OFFSET_W-1:0] in_offset,
    input  logic [LEN_W-1:0]    in_len,
    input  logic [7:0]          in_char,
    output logic                out_valid,
    output logic [7:0]          out_char,
    output logic                finish,
    output logic                err
);

    localparam int FILL_W = $clog2(SEARCH_DEPTH + 1);

    state_t              state;
    state_t              state_nxt;
    logic [OFFSET_W-1:0] offset_q;
    logic [LEN_W-1:0]    copy_cnt;
    logic [7:0]          char_q;
    logic                accept;
    logic                push;
    logic                emit;
    logic [7:0]          emit_char;
    logic [7:0]          rd_data;
    logic [FILL_W-1:0]   fill;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    lz77_search_buf #(
        .SEARCH_DEPTH (SEARCH_DEPTH),
        .OFFSET_W     (OFFSET_W),
        .FILL_W       (FILL_W)
    ) u_search_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (emit_char),
        .rd_offset (offset_q),
        .rd_data   (rd_data),
        .fill      (fill)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Copied characters are pushed back as they are emitted, so a fixed offset replicates overlapping matches.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        emit      = 1'b0;
        emit_char = 8'h00;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (in_len != '0) ? COPY : LIT;
                end
            end
            COPY: begin
                emit      = 1'b1;
                emit_char = rd_data;
                push      = 1'b1;
                if (copy_cnt == LEN_W'(1)) begin
                    state_nxt = LIT;
                end
            end
            LIT: begin
                emit      = 1'b1;
                emit_char = char_q;
                if (char_q == LZ77_END_CHAR) begin
                    state_nxt = DONE;
                end else begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset_q  <= '0;
            copy_cnt  <= '0;
            char_q    <= 8'h00;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            finish    <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_char <= emit_char;
            end
            if (accept) begin
                offset_q <= in_offset;
                copy_cnt <= in_len;
                char_q   <= in_char;
            end else if (state == COPY) begin
                copy_cnt <= copy_cnt - 1'b1;
            end
            if (state == LIT && char_q == LZ77_END_CHAR) begin
                finish <= 1'b1;
            end
        end
    end

`ifdef LZ77_DEC_CHECK_EN
    // Only flags the token; decoding carries on with whatever the buffer holds.
    logic bad_token;

    always_comb begin
        bad_token = (int'(in_offset) >= SEARCH_DEPTH) ||
                    ((in_len != '0) && (int'(in_offset) >= int'(fill))) ||
                    (int'(in_len) > MAX_LEN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && bad_token) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_ok;

    assign err       = 1'b0;
    assign unused_ok = &{1'b0, fill, (MAX_LEN > 0)};
`endif

endmodule

// File: doc/lz77_decoder.md
# lz77_decoder

Streaming LZ77 decoder: the stage directly downstream of the LZ77 encoder. It accepts (offset, match_len, char_nxt) tokens and reconstructs the original character stream, one character per cycle, using a sliding search buffer. It signals completion when it emits the end marker `8'h24` ('$').

## Interface
Parameters:
- `SEARCH_DEPTH`, default 7: search-buffer entries; legal offsets are 0..SEARCH_DEPTH-1.
- `MAX_LEN`, default 2: largest legal match_len.
- `OFFSET_W`, default 4: offset width.
- `LEN_W`, default 3: match_len width.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: token present.
- `in_ready`, out, 1: decoder can accept a token.
- `in_offset`, in, OFFSET_W: distance back into the search buffer; 0 = most recent character.
- `in_len`, in, LEN_W: number of characters to copy.
- `in_char`, in, 8: literal that follows the copied characters.
- `out_valid`, out, 1: `out_char` valid this cycle.
- `out_char`, out, 8: decoded character.
- `finish`, out, 1: end marker has been emitted; sticky.
- `err`, out, 1: sticky protocol-error flag; see Configuration.

## Operation
- **States:**
  - IDLE: `in_ready`=1.
  - COPY: emit copied characters.
  - LIT: emit the literal.
  - DONE: terminal.
- **Accept:** a token is accepted on a rising edge with `in_valid && in_ready`. The decoder latches offset, len and char, loads `copy_cnt`=len, then goes to COPY if len>0, else LIT.
- **COPY (one char per cycle):**
  - Registered output: `out_char` <= `sbuf[offset]`, `out_valid` <= 1.
  - The same character is pushed into `sbuf[0]`, and the buffer shifts (`sbuf[i]` <= `sbuf[i-1]`).
  - `copy_cnt` decrements; when it reaches 1, go to LIT.
  - Offset is not adjusted between copies, so overlapping matches replicate correctly.
- **LIT:**
  - `out_char` <= latched char, `out_valid` <= 1.
  - If char == `8'h24`: `finish` <= 1, no push, go to DONE.
  - Otherwise push the char into `sbuf[0]` and go to IDLE.
- **DONE:** `in_ready`=0 and `out_valid`=0 until reset. Tokens presented here are ignored.
- **Fill count:** saturates at SEARCH_DEPTH and increments on every push.
- **Empty entries:** reading an unfilled or out-of-range entry returns `8'h00`. Offsets ≥ SEARCH_DEPTH read as `8'h00`.
- **Backpressure:** none on the output. The consumer must take every `out_valid` beat.

## Timing
- **Reset values:**
  - `in_ready`=1 once out of reset (state IDLE).
  - `out_valid`=0, `out_char`=`8'h00`, `finish`=0, `err`=0.
  - All `sbuf` entries `8'h00`, fill count 0.
- **Latency:** first output beat appears on the edge after the accept edge.
- **Token occupancy:** a token with len L occupies L+1 output cycles, plus the one accept cycle in IDLE. Throughput is L+1 chars per L+2 cycles.
- **Output pulses:** `out_valid` is a one-cycle pulse per character. `finish` rises on the same edge as `out_valid` for `8'h24` and stays high.
- **in_ready:** is a pure function of state (IDLE). Input fields need only be stable in the accept cycle.
- **Reset mid-COPY/LIT:** outputs and buffer clear immediately (asynchronous). The partially decoded token is discarded.

## Configuration
- **`LZ77_DEC_CHECK_EN` defined:** on accept, `err` <= 1 (sticky until reset) if any of these hold:
  - offset ≥ SEARCH_DEPTH;
  - len>0 and offset ≥ fill count;
  - len > MAX_LEN.
  
  Decoding proceeds regardless.
- **`LZ77_DEC_CHECK_EN` undefined:** `err` is tied to 0 and no checking logic is built.

## Structure
- **Package `lz77_pkg`:**
  - State enum (IDLE, COPY, LIT, DONE).
  - `LZ77_END_CHAR` = `8'h24`.
  - Default SEARCH_DEPTH, MAX_LEN, OFFSET_W, LEN_W.
- **Sub-module `lz77_search_buf`:**
  - SEARCH_DEPTH×8 shift register with push enable and one combinational read port by offset (out-of-range → 0).
  - Owns the saturating fill counter.
- **Top:** FSM, token latches, output registers, error check.

## Test plan
- **Literals then copy:** tokens (0,0,`01`), (0,0,`02`), (1,2,`03`) -> `out_char` sequence `01 02 01 02 03`, one `out_valid` pulse each; `finish`=0.
- **Overlapping copy:** (0,0,`05`), (0,2,`06`) -> `05 05 05 06`; `in_ready` low during the 3 beats of the second token.
- **End marker:** after (0,0,`07`), send (0,1,`24`) -> outputs `07 07 24`. `finish` rises with the `24` beat. `in_ready` stays 0 afterwards; a further `in_valid` produces no output.
- **Backpressure:** hold `in_valid` with token (0,0,`09`) continuously across a busy token -> accepted exactly once, `09` emitted once.
- **Checks (macro defined):** on a fresh decoder, send (5,1,`01`) -> `err`=1 on the accept edge, output `00 01`. With the macro undefined, the same stimulus leaves `err`=0.
- **Reset mid-COPY:** assert `reset` during the second beat of (0,2,`06`) -> `out_valid`=0, `in_ready`=1 after release. Next token (0,1,`08`) outputs `00 08` because the buffer was cleared.
